// File: rtl/axis_fifo_sync.sv
// Single-clock first-word-fall-through AXI-Stream FIFO. Registers the ready
// path so consumer back-pressure never reaches the upstream mux combinationally.
module axis_fifo_sync #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW:0]      count
);

  // Handshake: a beat transfers on a rising edge where valid && ready; the
  // sender holds valid and data stable until then, and ready/valid here are
  // derived only from registered pointers.

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Index bits equal: empty if the wrap bits match, full if they differ.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr[AW-1:0]];
  assign count     = wr_ptr - rd_ptr;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= in_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: tb/tb_axis_fifo_sync.sv
// Directed and scoreboarded checks for axis_fifo_sync (WIDTH 16, DEPTH 8).
module tb_axis_fifo_sync;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [AW:0]      count;

  int n_vec;
  int n_err;
  logic [WIDTH-1:0] exp_q[$];

  axis_fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one edge; inputs change and outputs are sampled 1 ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_count"},     32'(count),     32'd0);
    check({tag, "_out_data"},  32'(out_data),  32'd0);
  endtask

  task automatic push_beat(input logic [WIDTH-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] ovf_exp [DEPTH+1];
    logic             pending;
    int               model_cnt;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #3;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // fill with out_ready low; head must stay at the first beat
    for (int i = 1; i <= DEPTH; i++) begin
      push_beat(WIDTH'(i));
      check("fill_count", 32'(count), 32'(i));
      check("fill_in_ready", 32'(in_ready), (i < DEPTH) ? 32'd1 : 32'd0);
      check("fill_head", 32'(out_data), 32'h0001);
    end

    // drain in order
    out_ready = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_data", 32'(out_data), 32'(i));
      step();
    end
    check("drain_empty", 32'(out_valid), 32'd0);
    check("drain_count", 32'(count), 32'd0);
    out_ready = 1'b0;

    // overflow attempt while full, then one pop frees a slot
    for (int i = 0; i < DEPTH; i++) push_beat(WIDTH'(16'h0011 + i));
    in_valid = 1'b1; in_data = 16'h00FF;
    step();
    check("ovf_count", 32'(count), 32'd8);
    check("ovf_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("ovf_pop_count", 32'(count), 32'd7);
    check("ovf_ready_rise", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("ovf_accept_count", 32'(count), 32'd8);
    for (int i = 0; i < DEPTH - 1; i++) ovf_exp[i] = WIDTH'(16'h0012 + i);
    ovf_exp[DEPTH-1] = 16'h00FF;
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("ovf_drain_data", 32'(out_data), 32'(ovf_exp[i]));
      step();
    end
    check("ovf_drain_empty", 32'(out_valid), 32'd0);

    // streaming 20 beats at full rate
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = WIDTH'(i); out_ready = 1'b1;
      if (i > 0) begin
        check("stream_valid", 32'(out_valid), 32'd1);
        check("stream_data", 32'(out_data), 32'(i - 1));
      end
      step();
      check("stream_count", 32'(count), 32'd1);
    end
    in_valid = 1'b0;
    check("stream_last", 32'(out_data), 32'd19);
    step();
    check("stream_end_count", 32'(count), 32'd0);
    out_ready = 1'b0;

    // simultaneous push and pop at count 4
    for (int i = 0; i < 4; i++) push_beat(WIDTH'(16'h0041 + i));
    in_valid = 1'b1; in_data = 16'h0045; out_ready = 1'b1;
    check("sim_head_before", 32'(out_data), 32'h0041);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("sim_count", 32'(count), 32'd4);
    check("sim_head_after", 32'(out_data), 32'h0042);

    // asynchronous reset with 5 entries held
    push_beat(16'h0046);
    check("pre_rst_count", 32'(count), 32'd5);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;

    // random back-pressure against the scoreboard
    model_cnt = 0;
    pending   = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (!pending) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = WIDTH'($urandom_range(0, 16'hFFFF));
      end
      out_ready = 1'($urandom_range(0, 1));
      check("rnd_in_ready", 32'(in_ready), (model_cnt < DEPTH) ? 32'd1 : 32'd0);
      check("rnd_out_valid", 32'(out_valid), (model_cnt != 0) ? 32'd1 : 32'd0);
      if (model_cnt != 0) check("rnd_out_data", 32'(out_data), 32'(exp_q[0]));
      pending = in_valid && (model_cnt == DEPTH);
      if (out_ready && model_cnt != 0) begin
        void'(exp_q.pop_front());
        model_cnt--;
      end
      if (in_valid && !pending) begin
        exp_q.push_back(in_data);
        model_cnt++;
      end
      step();
      check("rnd_count", 32'(count), 32'(model_cnt));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
